alu_issue_stage: RTL and testbench

Execute-stage front end that drives the shared 32-bit ALU and consumes its results. It accepts decoded RISC-V OP/OP-IMM requests over a valid/ready handshake, registers them and translates funct3/funct7 into the ALU's G_Select code. It drives the operands, then captures Result/V/C into an output register, deriving SLT/SLTU locally. It sits between decode and writeback: two registered stages, with a throughput of one operation per cycle.

---
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Two-stage execute front end: registers decoded OP/OP-IMM requests, drives the shared ALU
// and captures its result. Define ALU_FLAGS_EN to add the registered out_flags {N,Z,C,V} port.
module alu_issue_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic             in_is_imm,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [2:0]       alu_g_select,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       out_flags,
`endif
    output logic             out_err
);

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_XOR = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b100;
    localparam logic [2:0] SEL_AND = 3'b110;

    logic             vld_p0;
    logic             vld_p1;
    logic             w_adv;
    logic             accept;
    logic [2:0]       funct3_p0;
    logic             funct7_5_p0;
    logic             is_imm_p0;
    logic [31:0]      a_p0;
    logic [31:0]      b_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [31:0]      result_d;
    logic             err_d;

    function automatic logic [2:0] decode_sel(input logic [2:0] f3, input logic f7, input logic imm);
        case (f3)
            3'b000:         decode_sel = (f7 & ~imm) ? SEL_SUB : SEL_ADD;
            3'b010, 3'b011: decode_sel = SEL_SUB;
            3'b100:         decode_sel = SEL_XOR;
            3'b110:         decode_sel = SEL_OR;
            3'b111:         decode_sel = SEL_AND;
            default:        decode_sel = SEL_ADD;
        endcase
    endfunction

    // SLT uses the true sign of A-B (sign corrected by overflow); SLTU borrows when carry is clear.
    function automatic logic [31:0] form_result(input logic [2:0] f3, input logic [31:0] res,
                                                input logic v, input logic c);
        case (f3)
            3'b010:         form_result = {31'b0, res[31] ^ v};
            3'b011:         form_result = {31'b0, ~c};
            3'b001, 3'b101: form_result = 32'b0;
            default:        form_result = res;
        endcase
    endfunction

    assign w_adv    = ~vld_p1 | out_ready;
    assign in_ready = ~vld_p0 | w_adv;
    assign accept   = in_valid & in_ready;

    // Stage p0 (E): request register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (in_ready) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_p0   <= in_funct3;
            funct7_5_p0 <= in_funct7_5;
            is_imm_p0   <= in_is_imm;
            a_p0        <= in_a;
            b_p0        <= in_b;
            tag_p0      <= in_tag;
        end
    end

    always_comb begin
        alu_g_select = SEL_ADD;
        alu_a        = 32'b0;
        alu_b        = 32'b0;
        if (vld_p0) begin
            alu_g_select = decode_sel(funct3_p0, funct7_5_p0, is_imm_p0);
            alu_a        = a_p0;
            alu_b        = b_p0;
        end
    end

    assign result_d = form_result(funct3_p0, alu_result, alu_v, alu_c);
    assign err_d    = (funct3_p0[1:0] == 2'b01);

    // Stage p1 (W): output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            out_result <= 32'b0;
            out_tag    <= '0;
            out_err    <= 1'b0;
`ifdef ALU_FLAGS_EN
            out_flags  <= 4'b0;
`endif
        end else if (w_adv) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                out_result <= result_d;
                out_tag    <= tag_p0;
                out_err    <= err_d;
`ifdef ALU_FLAGS_EN
                out_flags  <= err_d ? 4'b0 : {alu_result[31], alu_result == 32'b0, alu_c, alu_v};
`endif
            end
        end
    end

    assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage with an in-bench ALU and a queue-based
// reference model of the operation stream; define ALU_FLAGS_EN to also check out_flags.
module tb_alu_issue_stage;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_funct3 = 3'b0;
    logic             in_funct7_5 = 1'b0;
    logic             in_is_imm = 1'b0;
    logic [31:0]      in_a = 32'b0;
    logic [31:0]      in_b = 32'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [2:0]       alu_g_select;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_v;
    logic             alu_c;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
`ifdef ALU_FLAGS_EN
    logic [3:0]       out_flags;
`endif

    alu_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_g_select(alu_g_select), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_v(alu_v), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
`ifdef ALU_FLAGS_EN
        .out_flags(out_flags),
`endif
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Shared ALU: adder with optional invert+carry-in, plus xor/or/and.
    logic [31:0] alu_bb;
    logic [32:0] alu_sum;
    always_comb begin
        alu_bb  = alu_g_select[0] ? ~alu_b : alu_b;
        alu_sum = {1'b0, alu_a} + {1'b0, alu_bb} + {32'b0, alu_g_select[0]};
        case (alu_g_select[2:1])
            2'b00:   alu_result = alu_sum[31:0];
            2'b01:   alu_result = alu_a ^ alu_b;
            2'b10:   alu_result = alu_a | alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
        alu_c = alu_sum[32];
        alu_v = (alu_a[31] == alu_bb[31]) && (alu_sum[31] != alu_a[31]);
    end

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [3:0]       flags;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic imm,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        sub;
        logic [32:0] s;
        logic [31:0] raw;
        logic        ovf;
        e.tag = '0;
        e.cyc = 0;
        e.err = (f3 == 3'b001) || (f3 == 3'b101);
        case (f3)
            3'b000:  e.res = (f7 && !imm) ? a - b : a + b;
            3'b010:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  e.res = (a < b) ? 32'd1 : 32'd0;
            3'b100:  e.res = a ^ b;
            3'b110:  e.res = a | b;
            3'b111:  e.res = a & b;
            default: e.res = 32'd0;
        endcase
        sub = (f3 == 3'b000 && f7 && !imm) || f3 == 3'b010 || f3 == 3'b011;
        s   = sub ? {1'b0, a} - {1'b0, b} + 33'h1_0000_0000 : {1'b0, a} + {1'b0, b};
        ovf = sub ? (a[31] != b[31]) && (s[31] != a[31]) : (a[31] == b[31]) && (s[31] != a[31]);
        case (f3)
            3'b100:  raw = a ^ b;
            3'b110:  raw = a | b;
            3'b111:  raw = a & b;
            default: raw = s[31:0];
        endcase
        e.flags = e.err ? 4'b0 : {raw[31], raw == 32'b0, s[32], ovf};
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the model queue (head = oldest in-flight op).
    logic             hold = 1'b0;
    logic [31:0]      h_res;
    logic [TAG_W-1:0] h_tag;
    logic             h_err;
`ifdef ALU_FLAGS_EN
    logic [3:0]       h_flags;
`endif
    always @(negedge clk) begin
        exp_t e;
        logic exp_vld;
        if (rst) begin
            hold = 1'b0;
        end else begin
            exp_vld = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            chk("out_valid", 32'(out_valid), 32'(exp_vld));
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", out_result, h_res);
                chk("hold_tag", 32'(out_tag), 32'(h_tag));
                chk("hold_err", 32'(out_err), 32'(h_err));
`ifdef ALU_FLAGS_EN
                chk("hold_flags", 32'(out_flags), 32'(h_flags));
`endif
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("result", out_result, e.res);
                chk("tag", 32'(out_tag), 32'(e.tag));
                chk("err", 32'(out_err), 32'(e.err));
`ifdef ALU_FLAGS_EN
                chk("flags", 32'(out_flags), 32'(e.flags));
`endif
            end
            if (in_valid && in_ready) begin
                e     = model(in_funct3, in_funct7_5, in_is_imm, in_a, in_b);
                e.tag = in_tag;
                e.cyc = cyc;
                q.push_back(e);
            end
            hold  = out_valid && !out_ready;
            h_res = out_result;
            h_tag = out_tag;
            h_err = out_err;
`ifdef ALU_FLAGS_EN
            h_flags = out_flags;
`endif
        end
    end

    task automatic set_op(input logic [2:0] f3, input logic f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        in_funct3 = f3; in_funct7_5 = f7; in_is_imm = imm; in_a = a; in_b = b; in_tag = tag;
    endtask

    // Present one op and return just after the edge that accepts it.
    task automatic send(input logic [2:0] f3, input logic f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int   g;
        logic acc;
        g = 0;
        set_op(f3, f7, imm, a, b, tag);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 50);
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic run_one(input string name, input logic [2:0] f3, input logic f7, input logic imm,
                           input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                           input logic [31:0] exp_res, input logic exp_err);
        int lat;
        out_ready = 1'b1;
        send(f3, f7, imm, a, b, TAG_W'($urandom));
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        chk({name, "_sel"}, 32'(alu_g_select), 32'(sel));
        chk({name, "_alu_a"}, alu_a, a);
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk(name, out_result, exp_res);
        chk({name, "_err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edge_vals [6];
        edge_vals = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        if ($urandom_range(0, 2) == 0) return edge_vals[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        exp_t m;

        // Model pins
        m = model(3'b000, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1);
        chk("model_sub", m.res, 32'h7FFF_FFFE);
        m = model(3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
        chk("model_slt", m.res, 32'h1);
        m = model(3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("model_xor", m.res, 32'h0FF0_0FF0);
        m = model(3'b101, 1'b0, 1'b0, 32'h5, 32'h3);
        chk("model_shift_err", 32'(m.err), 32'd1);
        m = model(3'b000, 1'b1, 1'b0, 32'h5, 32'h5);
        chk("model_flags_eq", 32'(m.flags), 32'h6);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("idle_sel", 32'(alu_g_select), 32'd0);
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        @(posedge clk);
        #1;

        run_one("add", 3'b000, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 3'b000, 32'h8000_0000, 1'b0);
        run_one("sub", 3'b000, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1, 3'b001, 32'h7FFF_FFFE, 1'b0);
        run_one("addi_f7", 3'b000, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1, 3'b000, 32'h8000_0000, 1'b0);
        run_one("slt_neg", 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 3'b001, 32'h1, 1'b0);
        run_one("sltu_neg", 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 3'b001, 32'h0, 1'b0);
        run_one("slt_ovf", 3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b001, 32'h1, 1'b0);
        run_one("sltu_ovf", 3'b011, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b001, 32'h0, 1'b0);
        run_one("xor", 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'h0FF0_0FF0, 1'b0);
        run_one("or", 3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'hFFF0_FFF0, 1'b0);
        run_one("and", 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b110, 32'hF000_F000, 1'b0);
        run_one("sll_err", 3'b001, 1'b0, 1'b0, 32'h1234_5678, 32'h4, 3'b000, 32'h0, 1'b1);

        // Back-to-back: eight results on consecutive cycles
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(3'b000, 1'b0, 1'b1, $urandom, $urandom, TAG_W'(i));
                in_valid = 1'b0;
            end
            begin
                int g;
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!out_valid && g < 20);
                for (int i = 0; i < 8; i++) begin
                    chk("b2b_valid", 32'(out_valid), 32'd1);
                    chk("b2b_tag", 32'(out_tag), 32'(i));
                    @(negedge clk);
                end
            end
        join
        @(posedge clk);
        #1;
        drain();

        // Backpressure: continuous stream into a stalled consumer
        out_ready = 1'b0;
        acc = 0;
        set_op(3'b000, 1'b0, 1'b0, pick_operand(), pick_operand(), TAG_W'(10));
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic a_now;
            @(negedge clk);
            a_now = in_ready;
            @(posedge clk);
            #1;
            if (a_now) begin
                acc++;
                set_op(3'($urandom), 1'($urandom), 1'($urandom), pick_operand(), pick_operand(),
                       TAG_W'(10 + acc));
            end
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(3'($urandom), 1'($urandom), 1'($urandom), pick_operand(), pick_operand(),
                 TAG_W'(20 + i));
        end
        drain();

        // Reset mid-stream
        for (int i = 0; i < 3; i++) send(3'b110, 1'b0, 1'b0, $urandom, $urandom, TAG_W'(i));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        run_one("post_rst_add", 3'b000, 1'b0, 1'b0, 32'h0000_0010, 32'hFFFF_FFF0, 3'b000, 32'h0, 1'b0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_op(3'($urandom), 1'($urandom), 1'($urandom), pick_operand(), pick_operand(),
                   TAG_W'($urandom));
            @(posedge clk);
            #1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
